pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Owns the architectural PC and issues instruction fetches to the icache port
// using the iREN/ihit handshake. A redirect that arrives while a fetch is
// outstanding is recorded and applied on the completing ihit, so the fetch
// address never changes mid-request. If ihit arrives while the pipeline is
// stalled, the instruction is parked in a one-entry skid register. A halt
// request is sticky until reset.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   pc_control    redirect request from the next-PC logic
//   nxt_pc        redirect target (bits [1:0] are ignored)
//   stall         downstream cannot accept an instruction this cycle
//   halt          stop fetching; enter the sticky halted state
//   ihit          memory returned the instruction for imemaddr
//   imemload      instruction data, valid with ihit
//   iREN          fetch request
//   imemaddr      fetch address (always equal to pc)
//   instr         registered instruction to IF/ID
//   instr_valid   instr is valid
//   pc            current PC
//   pc_plus4      pc + 4 (wraps)
//   halted        sticky halt indication
module pc_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pc_control,
  input  logic [WORD_W-1:0] nxt_pc,
  input  logic              stall,
  input  logic              halt,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;
  logic [WORD_W-1:0] skid_q;
  logic              pend_q;
  logic [WORD_W-1:0] raddr_q;

  logic [WORD_W-1:0] tgt_aligned;
  logic [WORD_W-1:0] pc_inc;

  assign tgt_aligned = {nxt_pc[WORD_W-1:2], 2'b00};
  assign pc_inc      = pc_q + WORD_W'(4);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= WORD_W'(PC_INIT);
      instr_q <= '0;
      valid_q <= 1'b0;
      skid_q  <= '0;
      pend_q  <= 1'b0;
      raddr_q <= '0;
    end else if (state_q == HALTED) begin
      // Sticky: everything held until reset.
    end else if (halt) begin
      state_q <= HALTED;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!ihit) begin
            // Address must stay stable; remember the redirect for the ihit edge.
            if (pc_control) begin
              pend_q  <= 1'b1;
              raddr_q <= tgt_aligned;
            end
            if (!stall) valid_q <= 1'b0;
          end else if (pc_control || pend_q) begin
            pc_q    <= pc_control ? tgt_aligned : raddr_q;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q <= imemload;
            valid_q <= 1'b1;
            pc_q    <= pc_inc;
          end else begin
            skid_q  <= imemload;
            pc_q    <= pc_inc;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (pc_control) begin
            pc_q    <= tgt_aligned;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (!stall) begin
            instr_q <= skid_q;
            valid_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: state_q <= HALTED;
      endcase
    end
  end

  assign iREN        = (state_q == FETCH) && !RST;
  assign imemaddr    = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_control;
  logic [31:0] nxt_pc;
  logic        stall;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;

  logic        iREN, instr_valid, halted;
  logic [31:0] imemaddr, instr, pc, pc_plus4;
  logic        w_iREN, w_instr_valid, w_halted;
  logic [31:0] w_imemaddr, w_instr, w_pc, w_pc_plus4;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .pc_control(pc_control), .nxt_pc(nxt_pc),
    .stall(stall), .halt(halt), .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .imemaddr(imemaddr), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  pc_fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .WORD_W(32)) dut_wrap (
    .CLK(CLK), .RST(RST), .pc_control(pc_control), .nxt_pc(nxt_pc),
    .stall(stall), .halt(halt), .ihit(ihit), .imemload(imemload),
    .iREN(w_iREN), .imemaddr(w_imemaddr), .instr(w_instr),
    .instr_valid(w_instr_valid), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .halted(w_halted)
  );

  typedef struct {
    logic        pcc;
    logic [31:0] nxt;
    logic        stl;
    logic        hlt;
    logic        hit;
    logic [31:0] ld;
    logic        e_iren;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_v;
    logic        e_h;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pcc, input logic [31:0] nxt, input logic stl,
                     input logic hlt, input logic hit, input logic [31:0] ld,
                     input logic e_iren, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic e_v, input logic e_h);
    vec_t v;
    v.pcc = pcc; v.nxt = nxt; v.stl = stl; v.hlt = hlt; v.hit = hit; v.ld = ld;
    v.e_iren = e_iren; v.e_pc = e_pc; v.e_instr = e_instr; v.e_v = e_v; v.e_h = e_h;
    tbl.push_back(v);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pcc, input logic [31:0] nxt, input logic stl,
                       input logic hlt, input logic hit, input logic [31:0] ld);
    pc_control = pcc; nxt_pc = nxt; stall = stl; halt = hlt; ihit = hit; imemload = ld;
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Columns: pc_control nxt_pc stall halt ihit imemload | iREN pc instr valid halted
    // Back-to-back fetch from 0
    add(0, 32'h0,   0, 0, 1, 32'hA0, 1, 32'h04,  32'hA0, 1, 0);
    add(0, 32'h0,   0, 0, 1, 32'hA1, 1, 32'h08,  32'hA1, 1, 0);
    add(0, 32'h0,   0, 0, 1, 32'hA2, 1, 32'h0C,  32'hA2, 1, 0);
    add(0, 32'h0,   0, 0, 1, 32'hA3, 1, 32'h10,  32'hA3, 1, 0);
    // Redirect mid-fetch at 0x10 -> 0x40
    add(1, 32'h40,  0, 0, 0, 32'h0,  1, 32'h10,  32'hA3, 0, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,  1, 32'h10,  32'hA3, 0, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,  1, 32'h10,  32'hA3, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hBAD,1, 32'h40,  32'hA3, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hB0, 1, 32'h44,  32'hB0, 1, 0);
    // Newer pending redirect overwrites older (0x22 aligns to 0x20)
    add(1, 32'h80,  0, 0, 0, 32'h0,  1, 32'h44,  32'hB0, 0, 0);
    add(1, 32'h22,  0, 0, 0, 32'h0,  1, 32'h44,  32'hB0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hBAD,1, 32'h20,  32'hB0, 0, 0);
    // Redirect coincident with ihit, 0x103 -> 0x100
    add(1, 32'h103, 0, 0, 1, 32'hBAD,1, 32'h100, 32'hB0, 0, 0);
    // Same-cycle target beats pending one
    add(1, 32'h200, 0, 0, 0, 32'h0,  1, 32'h100, 32'hB0, 0, 0);
    add(1, 32'h300, 0, 0, 1, 32'hBAD,1, 32'h300, 32'hB0, 0, 0);
    // Skid: fetch at 0x8 under stall
    add(1, 32'h4,   0, 0, 1, 32'hBAD,1, 32'h04,  32'hB0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hC0, 1, 32'h08,  32'hC0, 1, 0);
    add(0, 32'h0,   1, 0, 1, 32'hDEADBEEF, 0, 32'h0C, 32'hC0, 1, 0);
    add(0, 32'h0,   1, 0, 0, 32'h0,  0, 32'h0C,  32'hC0, 1, 0);
    add(0, 32'h0,   1, 0, 1, 32'hBAD,0, 32'h0C,  32'hC0, 1, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,  1, 32'h0C,  32'hDEADBEEF, 1, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,  1, 32'h0C,  32'hDEADBEEF, 0, 0);
    // Redirect out of HOLD
    add(0, 32'h0,   1, 0, 1, 32'hD0, 0, 32'h10,  32'hDEADBEEF, 0, 0);
    add(1, 32'h51,  1, 0, 0, 32'h0,  1, 32'h50,  32'hDEADBEEF, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hE0, 1, 32'h54,  32'hE0, 1, 0);
    // Stall without ihit holds valid; release drops it
    add(0, 32'h0,   1, 0, 0, 32'h0,  1, 32'h54,  32'hE0, 1, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,  1, 32'h54,  32'hE0, 0, 0);
    // Halt at 0x30 with a concurrent ihit
    add(1, 32'h2C,  0, 0, 1, 32'hBAD,1, 32'h2C,  32'hE0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hE1, 1, 32'h30,  32'hE1, 1, 0);
    add(0, 32'h0,   0, 1, 1, 32'hBAD,0, 32'h30,  32'hE1, 0, 1);
    add(1, 32'h80,  0, 0, 1, 32'hBAD,0, 32'h30,  32'hE1, 0, 1);
    add(0, 32'h0,   0, 0, 1, 32'hBAD,0, 32'h30,  32'hE1, 0, 1);

    // Reset for two cycles
    @(posedge CLK); @(posedge CLK); #1;
    check1("rst_iren", {31'b0, iREN}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check1("rst_pc",     pc,          32'h0);
    check1("rst_plus4",  pc_plus4,    32'h4);
    check1("rst_valid",  {31'b0, instr_valid}, 32'h0);
    check1("rst_instr",  instr,       32'h0);
    check1("rst_iren1",  {31'b0, iREN}, 32'h1);
    check1("rst_halted", {31'b0, halted}, 32'h0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i].pcc, tbl[i].nxt, tbl[i].stl, tbl[i].hlt, tbl[i].hit, tbl[i].ld);
      @(posedge CLK); #1;
      checks++;
      if (iREN !== tbl[i].e_iren || pc !== tbl[i].e_pc || imemaddr !== tbl[i].e_pc ||
          pc_plus4 !== tbl[i].e_pc + 32'd4 || instr !== tbl[i].e_instr ||
          instr_valid !== tbl[i].e_v || halted !== tbl[i].e_h) begin
        failures++;
        $display("FAIL vec%0d: got iREN=%b pc=%h addr=%h p4=%h instr=%h v=%b h=%b expected iREN=%b pc=%h instr=%h v=%b h=%b",
                 i, iREN, pc, imemaddr, pc_plus4, instr, instr_valid, halted,
                 tbl[i].e_iren, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_v, tbl[i].e_h);
      end
    end

    // Reset exits HALTED; iREN forced low while RST is high
    @(negedge CLK);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    RST = 1'b1;
    #1;
    check1("rst2_iren_low", {31'b0, iREN}, 32'h0);
    @(posedge CLK); #1;
    check1("rst2_halted", {31'b0, halted}, 32'h0);
    check1("rst2_pc", pc, 32'h0);
    check1("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    check1("wrap_plus4", w_pc_plus4, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check1("rst2_iren_high", {31'b0, iREN}, 32'h1);
    // One fetch: wrap instance rolls over to 0
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hF00D);
    @(posedge CLK); #1;
    check1("wrap_pc", w_imemaddr, 32'h0);
    check1("wrap_instr", w_instr, 32'hF00D);
    check1("restart_pc", pc, 32'h4);
    check1("restart_valid", {31'b0, instr_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
